memory_responder: RTL and testbench

- Memory-side responder for the CPU's two memory request streams: instruction fetch (IF) and data load/store (D).
- Owns a single-port synchronous storage array and serves one request at a time over a valid/ready request handshake.
- Each request returns a one-cycle response pulse after a programmable access latency.
- Replaces the combinational single-port memory plus stage-gated address muxing; enables a stall-driven pipeline.

---
 rtl/memory_responder_pkg.sv | 16 +
 rtl/memory_responder_if.sv | 30 +++
 rtl/memory_responder_array.sv | 24 ++
 rtl/memory_responder.sv | 114 +++++++++++
 tb/tb_memory_responder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: word width, FSM encoding and
// request source IDs.
package memory_responder_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;
endpackage

// File: rtl/memory_responder_if.sv
// Request/response bundle between the CPU (master) and the memory responder (slave).
interface memory_responder_if;
  import memory_responder_pkg::*;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [WORD_W-1:0] if_req_addr;
  logic              if_resp_valid;
  logic [WORD_W-1:0] if_resp_data;
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_wen;
  logic [WORD_W-1:0] d_req_addr;
  logic [WORD_W-1:0] d_req_wdata;
  logic              d_resp_valid;
  logic [WORD_W-1:0] d_resp_data;
  logic              busy;

  modport master (
    output if_req_valid, if_req_addr, d_req_valid, d_req_wen, d_req_addr, d_req_wdata,
    input  if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid,
           d_resp_data, busy
  );

  modport slave (
    input  if_req_valid, if_req_addr, d_req_valid, d_req_wen, d_req_addr, d_req_wdata,
    output if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid,
           d_resp_data, busy
  );
endinterface

// File: rtl/memory_responder_array.sv
// DEPTH x 32 single-port storage: synchronous write, registered read, no reset.
module memory_responder_array
  import memory_responder_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/memory_responder.sv
// Single-outstanding memory responder serving IF and D request streams with a
// fixed access latency; data requests win over fetches.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  memory_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  src_e              r_src;
  logic              r_wen;
  logic [AW-1:0]     r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_if_data, r_d_data;
  logic [WORD_W-1:0] w_rdata, w_resp_data;
  logic              w_d_ready, w_if_ready, w_d_acc, w_if_acc, w_acc;
  logic              w_commit, w_resp, w_if_resp, w_d_resp;
  logic              w_unused_addr;

  assign w_d_ready  = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_if_ready = w_d_ready && !bus.d_req_valid;
  assign w_d_acc    = bus.d_req_valid && w_d_ready;
  assign w_if_acc   = bus.if_req_valid && w_if_ready;
  assign w_acc      = w_d_acc || w_if_acc;
  assign w_commit   = (r_state == ST_WAIT) && (r_cnt == '0);

  assign w_unused_addr = ^{bus.d_req_addr[WORD_W-1:AW], bus.if_req_addr[WORD_W-1:AW]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_acc) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CW'(LATENCY - 1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src   <= SRC_IF;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_acc) begin
      r_src   <= w_d_acc ? SRC_D : SRC_IF;
      r_wen   <= w_d_acc && bus.d_req_wen;
      r_addr  <= w_d_acc ? bus.d_req_addr[AW-1:0] : bus.if_req_addr[AW-1:0];
      r_wdata <= w_d_acc ? bus.d_req_wdata : '0;
    end
  end

  // Store commit and load read both land on the WAIT->RESP edge.
  memory_responder_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .i_clk   (clk),
    .i_we    (w_commit && r_wen),
    .i_re    (w_commit && !r_wen),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign w_resp      = (r_state == ST_RESP);
  assign w_d_resp    = w_resp && (r_src == SRC_D);
  assign w_if_resp   = w_resp && (r_src == SRC_IF);
  assign w_resp_data = r_wen ? r_wdata : w_rdata;

  // Response data is live during RESP and captured into a hold register on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_data <= '0;
      r_d_data  <= '0;
    end else begin
      if (w_if_resp) r_if_data <= w_resp_data;
      if (w_d_resp)  r_d_data  <= w_resp_data;
    end
  end

  assign bus.d_req_ready   = w_d_ready;
  assign bus.if_req_ready  = w_if_ready;
  assign bus.d_resp_valid  = w_d_resp;
  assign bus.if_resp_valid = w_if_resp;
  assign bus.d_resp_data   = w_d_resp  ? w_resp_data : r_d_data;
  assign bus.if_resp_data  = w_if_resp ? w_resp_data : r_if_data;
  assign bus.busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_memory_responder.sv
// Randomized + directed bench for memory_responder against a transaction-level model.
module tb_memory_responder;
  import memory_responder_pkg::*;

  localparam int DEPTH = 2048;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  memory_responder_if bus();

  memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one outstanding request that answers LAT edges after acceptance.
  logic [31:0] m_mem [int];
  bit          m_pend, m_src_d, m_wen, m_dv, m_iv, m_busy, m_dk, m_ik;
  int          m_left, m_addr;
  logic [31:0] m_wd, m_dd, m_id;

  always @(negedge clk) begin
    bit          k;
    logic [31:0] v;
    if (!rst) begin
      m_pend = 0; m_dv = 0; m_iv = 0; m_busy = 0;
      m_dd = '0; m_id = '0; m_dk = 1; m_ik = 1;
    end
    chk("busy", bus.busy, m_busy);
    chk("d_ready", bus.d_req_ready, !m_pend);
    chk("if_ready", bus.if_req_ready, !m_pend && !bus.d_req_valid);
    chk("d_resp_valid", bus.d_resp_valid, m_dv);
    chk("if_resp_valid", bus.if_resp_valid, m_iv);
    chk("resp_overlap", bus.d_resp_valid && bus.if_resp_valid, 0);
    if (m_dk) chk("d_resp_data", bus.d_resp_data, m_dd);
    if (m_ik) chk("if_resp_data", bus.if_resp_data, m_id);
    if (rst) begin
      m_dv = 0; m_iv = 0;
      if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_pend = 0;
          if (m_wen) begin
            m_mem[m_addr] = m_wd; v = m_wd; k = 1;
          end else begin
            k = m_mem.exists(m_addr);
            v = k ? m_mem[m_addr] : '0;
          end
          if (m_src_d) begin m_dv = 1; m_dd = v; m_dk = k; end
          else         begin m_iv = 1; m_id = v; m_ik = k; end
        end
      end else if (bus.d_req_valid) begin
        m_pend = 1; m_left = LAT; m_src_d = 1; m_wen = bus.d_req_wen;
        m_addr = int'(bus.d_req_addr % DEPTH); m_wd = bus.d_req_wdata;
      end else if (bus.if_req_valid) begin
        m_pend = 1; m_left = LAT; m_src_d = 0; m_wen = 0;
        m_addr = int'(bus.if_req_addr % DEPTH); m_wd = '0;
      end
      m_busy = m_pend || m_dv || m_iv;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic req(input bit is_d, input bit wen, input logic [31:0] a,
                     input logic [31:0] wd, input bit keep);
    int n = 0;
    bit acc;
    if (is_d) begin
      bus.d_req_valid = 1; bus.d_req_wen = wen; bus.d_req_addr = a; bus.d_req_wdata = wd;
    end else begin
      bus.if_req_valid = 1; bus.if_req_addr = a;
    end
    do begin
      @(negedge clk);
      n++;
      acc = is_d ? bus.d_req_ready : bus.if_req_ready;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) begin
      if (is_d) bus.d_req_valid = 0;
      else      bus.if_req_valid = 0;
    end
  endtask

  // Counts negedges until the port's response pulse; returns at posedge+1 after it.
  task automatic wait_resp(input bit is_d, output int n, output logic [31:0] d);
    bit v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      v = is_d ? bus.d_resp_valid : bus.if_resp_valid;
    end while (!v && n < 40);
    if (!v) chk("resp_timeout", 0, 1);
    d = is_d ? bus.d_resp_data : bus.if_resp_data;
    @(posedge clk); #1;
    chk("pulse_one_cycle", is_d ? bus.d_resp_valid : bus.if_resp_valid, 0);
  endtask

  initial begin
    int          n;
    logic [31:0] d;
    bus.if_req_valid = 0; bus.if_req_addr = '0;
    bus.d_req_valid = 0; bus.d_req_wen = 0; bus.d_req_addr = '0; bus.d_req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_d_valid", bus.d_resp_valid, 0);
    chk("rst_if_valid", bus.if_resp_valid, 0);
    chk("rst_d_data", bus.d_resp_data, 0);
    chk("rst_if_data", bus.if_resp_data, 0);
    @(posedge clk); #1 rst = 1;

    for (int i = 0; i < 16; i++) req(1, 1, i, 32'hC0DE_0000 + i, 0);
    wait_resp(1, n, d);

    // Store latency and echo, then fetch of the stored word
    req(1, 1, 5, 32'hDEAD_BEEF, 0);
    wait_resp(1, n, d);
    chk("store_latency", n, LAT + 1);
    chk("store_echo", d, 32'hDEAD_BEEF);
    req(0, 0, 5, 0, 0);
    wait_resp(0, n, d);
    chk("fetch_after_store", d, 32'hDEAD_BEEF);

    // Simultaneous IF and D: D wins, IF follows back-to-back
    bus.if_req_valid = 1; bus.if_req_addr = 0;
    bus.d_req_valid = 1; bus.d_req_wen = 0; bus.d_req_addr = 5;
    @(negedge clk);
    chk("prio_d_ready", bus.d_req_ready, 1);
    chk("prio_if_ready", bus.if_req_ready, 0);
    @(posedge clk); #1 bus.d_req_valid = 0;
    wait_resp(1, n, d);
    chk("prio_d_data", d, 32'hDEAD_BEEF);
    bus.if_req_valid = 0;
    wait_resp(0, n, d);
    chk("b2b_if_latency", n, LAT + 1);
    chk("b2b_if_data", d, 32'hC0DE_0000);

    // Burst of fetches with valid held high
    fork
      begin
        for (int k = 0; k < 4; k++) req(0, 0, k, 0, k < 3);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          int          nn;
          logic [31:0] dd;
          wait_resp(0, nn, dd);
          chk("burst_data", dd, 32'hC0DE_0000 + k);
          if (k > 0) chk("burst_interval", nn, LAT + 1);
        end
      end
    join

    // Address wrap
    req(1, 1, 2048, 32'h1234_5678, 0);
    wait_resp(1, n, d);
    req(1, 0, 0, 0, 0);
    wait_resp(1, n, d);
    chk("wrap_load", d, 32'h1234_5678);

    // Reset in the middle of a store drops it
    req(1, 1, 7, 32'hAAAA_0000, 0);
    wait_resp(1, n, d);
    req(1, 1, 7, 32'h5555_5555, 0);
    #2 rst = 0;
    #1;
    chk("midrst_d_valid", bus.d_resp_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_d_data", bus.d_resp_data, 0);
    @(posedge clk); #1 rst = 1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_resp", bus.d_resp_valid, 0);
    end
    @(posedge clk); #1;
    req(1, 0, 7, 0, 0);
    wait_resp(1, n, d);
    chk("midrst_old_value", d, 32'hAAAA_0000);

    // Inputs changed after acceptance are ignored
    req(1, 0, 3, 0, 0);
    bus.d_req_wen = 1; bus.d_req_addr = 9; bus.d_req_wdata = 32'hFFFF_FFFF;
    wait_resp(1, n, d);
    chk("latched_addr", d, 32'hC0DE_0003);

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a1, a2;
      int          r;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a1 = ($urandom & 32'hFFFF_F800) | $urandom_range(0, 15);
      a2 = ($urandom & 32'hFFFF_F800) | $urandom_range(0, 15);
      r  = $urandom_range(0, 3);
      if (r == 0) begin
        fork
          req(1, 1'($urandom), a1, $urandom, 0);
          req(0, 0, a2, 0, 0);
        join
      end else if (r == 3) begin
        req(0, 0, a1, 0, 0);
      end else begin
        req(1, 1'($urandom), a1, $urandom, 0);
      end
    end
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
